// File: rtl/alu_pkg.sv
// Shared definitions for iter_alu: op codes, FSM states and op-class decode.
// Optional divider: define ITER_ALU_DIV_EN to make DIV/REM iterative ops.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_XOR  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_SRAI = 4'd7;
  localparam logic [3:0] OP_DIV  = 4'd8;
  localparam logic [3:0] OP_REM  = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  typedef enum logic [1:0] {CLS_SINGLE, CLS_ITER, CLS_ILLEGAL} op_class_t;

  // Without the divider, codes 8/9 fall through to illegal.
  function automatic op_class_t op_class(input logic [3:0] op);
    case (op)
      OP_AND, OP_XOR, OP_SLL, OP_ADD,
      OP_SUB, OP_ADDI, OP_SRAI:       return CLS_SINGLE;
      OP_MUL:                         return CLS_ITER;
`ifdef ITER_ALU_DIV_EN
      OP_DIV, OP_REM:                 return CLS_ITER;
`endif
      default:                        return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier and (optional) restoring divider.
// One operand bit per cycle over WIDTH cycles; done_o flags the final step,
// during which result_o already carries the finished value.
// Optional divider: ITER_ALU_DIV_EN.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
`ifdef ITER_ALU_DIV_EN
  input  logic [3:0]       op_i,
`endif
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  // x: multiplier / dividend-then-quotient; y: multiplicand / divisor magnitude;
  // acc: product / partial remainder.
  logic               active_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   acc_q, x_q, y_q;
  logic [WIDTH-1:0]   acc_nxt, x_nxt, y_nxt;

`ifdef ITER_ALU_DIV_EN
  logic             div_q, rem_q, a_neg_q, q_neg_q, div0_q;
  logic             is_div;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_div = (op_i == OP_DIV) || (op_i == OP_REM);
  assign a_mag  = data1_i[WIDTH-1] ? -data1_i : data1_i;
  assign b_mag  = data2_i[WIDTH-1] ? -data2_i : data2_i;
`endif

  assign done_o = active_q && (cnt_q == CNT_LAST);

  // One iteration step plus the sign fix-up applied to the final step's value.
  always_comb begin
    acc_nxt  = acc_q;
    x_nxt    = x_q;
    y_nxt    = y_q;
`ifdef ITER_ALU_DIV_EN
    rem_sh   = '0;
    rem_sub  = '0;
    if (div_q) begin
      rem_sh  = {acc_q, x_q[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, y_q};
      x_nxt   = {x_q[WIDTH-2:0], 1'b0};
      if (rem_sh >= {1'b0, y_q}) begin
        acc_nxt  = rem_sub[WIDTH-1:0];
        x_nxt[0] = 1'b1;
      end else begin
        acc_nxt  = rem_sh[WIDTH-1:0];
      end
    end else
`endif
    begin
      acc_nxt = acc_q + (x_q[0] ? y_q : '0);
      x_nxt   = x_q >> 1;
      y_nxt   = y_q << 1;
    end
    result_o = acc_nxt;
`ifdef ITER_ALU_DIV_EN
    // Divide-by-zero remainder comes out as |a| and the fix-up restores a.
    // MIN / -1 falls out of the magnitude path without special handling.
    if (div_q) begin
      if (rem_q)       result_o = a_neg_q ? -acc_nxt : acc_nxt;
      else if (div0_q) result_o = '1;
      else             result_o = q_neg_q ? -x_nxt : x_nxt;
    end
`endif
  end

  // Operand capture at start, then one step per cycle until the last count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
`ifdef ITER_ALU_DIV_EN
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
`ifdef ITER_ALU_DIV_EN
      div_q    <= is_div;
      rem_q    <= (op_i == OP_REM);
      a_neg_q  <= data1_i[WIDTH-1];
      q_neg_q  <= data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
      div0_q   <= (data2_i == '0);
      if (is_div) begin
        x_q <= a_mag;
        y_q <= b_mag;
      end else
`endif
      begin
        x_q <= data2_i;
        y_q <= data1_i;
      end
    end else if (active_q) begin
      acc_q <= acc_nxt;
      x_q   <= x_nxt;
      y_q   <= y_nxt;
      if (done_o) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + SHAMT_W'(1);
      end
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/shift/add ops, iterative
// MUL and (with ITER_ALU_DIV_EN defined) DIV/REM through iter_muldiv.
//
// state  | meaning
// S_IDLE | ready; accepts any op, single-cycle results land here
// S_MUL  | shift-add multiply in flight
// S_DIV  | restoring divide in flight (divider builds only)
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [3:0]       ALUCtrl_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t             state_q, state_nxt;
  op_class_t          cls;
  logic               accept, start, md_done;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   single_res, md_result;

  assign cls     = op_class(ALUCtrl_i);
  assign ready_o = (state_q == S_IDLE);
  assign busy_o  = !ready_o;
  assign accept  = valid_i && ready_o;
  assign start   = accept && (cls == CLS_ITER);
  assign shamt   = data2_i[SHAMT_W-1:0];

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start),
`ifdef ITER_ALU_DIV_EN
    .op_i     (ALUCtrl_i),
`endif
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .done_o   (md_done),
    .result_o (md_result)
  );

  // Single-cycle datapath; illegal codes yield zero.
  always_comb begin
    single_res = '0;
    case (ALUCtrl_i)
      OP_AND:          single_res = data1_i & data2_i;
      OP_XOR:          single_res = data1_i ^ data2_i;
      OP_SLL:          single_res = data1_i << shamt;
      OP_ADD, OP_ADDI: single_res = data1_i + data2_i;
      OP_SUB:          single_res = data1_i - data2_i;
      OP_SRAI:         single_res = $signed(data1_i) >>> shamt;
      default:         single_res = '0;
    endcase
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (start) state_nxt = (ALUCtrl_i == OP_MUL) ? S_MUL : S_DIV;
      S_MUL,
      S_DIV:  if (md_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  // Result register with one-cycle valid pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept && (cls != CLS_ITER)) begin
        data_o  <= single_res;
        valid_o <= 1'b1;
      end else if (md_done) begin
        data_o  <= md_result;
        valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed vector table, hand-written
// multi-cycle sequences and randomized ops against an arithmetic model.
module tb_iter_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic         ready, valid_out, busy;
  logic [W-1:0] d1 = '0, d2 = '0, dout;
  logic [3:0]   op = '0;

  int n_checks = 0;
  int n_errors = 0;

  iter_alu #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (valid),
    .ready_o   (ready),
    .data1_i   (d1),
    .data2_i   (d2),
    .ALUCtrl_i (op),
    .data_o    (dout),
    .valid_o   (valid_out),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[$];

`ifdef ITER_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_iter(input logic [3:0] o);
    return (o == 4'd5) || (DIV_EN && (o == 4'd8 || o == 4'd9));
  endfunction

  // Behavioural reference: plain signed arithmetic on 64-bit values.
  function automatic logic [W-1:0] ref_result(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      4'd0: return a & b;
      4'd1: return a ^ b;
      4'd2: return a << b[4:0];
      4'd3, 4'd6: return a + b;
      4'd4: return a - b;
      4'd5: begin p = sa * sb; return p[W-1:0]; end
      4'd7: return $signed(a) >>> b[4:0];
      4'd8: if (DIV_EN) begin
              if (b == 0) return '1;
              p = sa / sb;
              return p[W-1:0];
            end else return '0;
      4'd9: if (DIV_EN) begin
              if (b == 0) return a;
              p = sa % sb;
              return p[W-1:0];
            end else return '0;
      default: return '0;
    endcase
  endfunction

  // Issue one op (DUT must be ready), wait for its result, check latency,
  // busy window and value. Returns in the cycle valid_o is high.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string name);
    int lat, bad;
    int exp_lat;
    exp_lat = is_iter(o) ? W + 1 : 1;
    op = o; d1 = a; d2 = b; valid = 1'b1;
    step();
    valid = 1'b0;
    d1 = $urandom; d2 = $urandom; op = 4'($urandom);
    lat = 1;
    bad = 0;
    while (!valid_out && lat < 3 * W) begin
      if (ready !== 1'b0 || busy !== 1'b1) bad++;
      step();
      lat++;
    end
    check({name, " latency"}, W'(lat), W'(exp_lat));
    check({name, " data"}, dout, exp);
    check({name, " ready at result"}, W'(ready), W'(1));
    if (exp_lat > 1) check({name, " busy window"}, W'(bad), W'(0));
  endtask

  initial begin
    int pulses;

    // Directed vectors, applied back to back.
    vecs.push_back('{4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "add_ovf"});
    vecs.push_back('{4'd4, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, "sub_neg"});
    vecs.push_back('{4'd7, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, "srai_31"});
    vecs.push_back('{4'd2, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, "sll_mask"});
    vecs.push_back('{4'd0, 32'hF0F0_00FF, 32'h0FF0_F0F0, 32'h00F0_00F0, "and"});
    vecs.push_back('{4'd1, 32'hF0F0_00FF, 32'h0FF0_F0F0, 32'hFF00_F00F, "xor"});
    vecs.push_back('{4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "addi_wrap"});
    vecs.push_back('{4'd15, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, "illegal_15"});
    vecs.push_back('{4'd10, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, "illegal_10"});
    vecs.push_back('{4'd5, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, "mul_m3x7"});
`ifdef ITER_ALU_DIV_EN
    vecs.push_back('{4'd8, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2"});
    vecs.push_back('{4'd9, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2"});
    vecs.push_back('{4'd8, 32'h0000_0063, 32'h0000_0000, 32'hFFFF_FFFF, "div_by0"});
    vecs.push_back('{4'd9, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, "rem_by0"});
    vecs.push_back('{4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
    vecs.push_back('{4'd9, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"});
`else
    vecs.push_back('{4'd8, 32'h0000_0063, 32'h0000_0002, 32'h0000_0000, "op8_illegal"});
    vecs.push_back('{4'd9, 32'h0000_0063, 32'h0000_0002, 32'h0000_0000, "op9_illegal"});
`endif

    // Reset values.
    repeat (3) step();
    rst = 1'b0;
    check("reset data_o", dout, '0);
    check("reset valid_o", W'(valid_out), '0);
    check("reset ready_o", W'(ready), W'(1));
    check("reset busy_o", W'(busy), '0);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // MUL with a request held high while busy: must not be taken early.
    op = 4'd5; d1 = 32'hFFFF_FFFD; d2 = 32'd7; valid = 1'b1;
    step();
    op = 4'd3; d1 = 32'd1; d2 = 32'd1;
    pulses = 0;
    for (int c = 1; c <= W; c++) begin
      if (ready !== 1'b0 || valid_out !== 1'b0) pulses++;
      step();
    end
    check("held mul early activity", W'(pulses), '0);
    check("held mul valid at k+33", W'(valid_out), W'(1));
    check("held mul data", dout, 32'hFFFF_FFEB);
    step();
    valid = 1'b0;
    check("held add valid", W'(valid_out), W'(1));
    check("held add data", dout, 32'd2);

    // Reset in cycle k+10 of a MUL aborts it.
    op = 4'd5; d1 = 32'd3; d2 = 32'd5; valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort valid_o", W'(valid_out), '0);
    check("abort ready_o", W'(ready), W'(1));
    check("abort data_o", dout, '0);
    run_op(4'd3, 32'd2, 32'd3, 32'd5, "post_abort_add");
    pulses = 0;
    for (int c = 0; c < 2 * W; c++) begin
      step();
      if (valid_out) pulses++;
    end
    check("abort no late valid", W'(pulses), '0);

    // Reset dominates a same-cycle request.
    op = 4'd3; d1 = 32'd1; d2 = 32'd1; valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; valid = 1'b0;
    check("rst vs valid valid_o", W'(valid_out), '0);
    check("rst vs valid data_o", dout, '0);
    step();
    check("rst vs valid no late", W'(valid_out), '0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [3:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: ra = '1;
        2: ra = 32'h8000_0000;
        3: ra = W'($urandom_range(0, 40));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = '1;
        2: rb = 32'h8000_0000;
        3: rb = W'($urandom_range(0, 40));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, ref_result(ro, ra, rb), $sformatf("rand%0d op%0d", i, ro));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
